instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Multi-cycle instruction fetch/issue sequencer for the 16-bit Harvard core.
- Owns the PC and reads instruction memory over a req/ack handshake.
- Presents the fetched word and its 3-bit opcode field to the control decoder.
- Consumes the decoder's jump/branch results, together with the ALU zero flag, to select the next PC.

Parameters:
PC_WIDTH, 16, width of PC and instruction-memory address
RESET_PC, 16'h0000, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  PC_WIDTH  fetch address (equals pc)
imem_rdata  in  16  instruction word, valid when imem_ack=1
imem_ack  in  1  memory accepts request and returns data this cycle
stall  in  1  downstream not ready; hold current instruction
jump  in  1  decoder: unconditional jump for issued instruction
branch  in  1  decoder: conditional branch for issued instruction
zero  in  1  ALU zero flag for issued instruction
jump_addr  in  PC_WIDTH  absolute jump target
branch_offset  in  PC_WIDTH  sign-extended branch offset
instr  out  16  issued instruction word
opcode  out  3  instr[15:13], to control decoder
instr_valid  out  1  instr/opcode valid this cycle
pc  out  PC_WIDTH  address of issued instruction
pc_plus1  out  PC_WIDTH  pc+1, modulo 2^PC_WIDTH

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on port reset; all state updates on the rising edge of clk.
- While reset=1:
  - state=S_IDLE, pc=RESET_PC, instr=16'h0000.
  - imem_req=0, instr_valid=0, imem_addr=RESET_PC.
- FSM states: S_IDLE, S_FETCH, S_ISSUE.
- S_IDLE: outputs idle; next state S_FETCH unconditionally. Gives exactly one dead cycle after reset release.
- S_FETCH:
  - imem_req=1, imem_addr=pc, instr_valid=0.
  - imem_addr held stable while imem_req=1.
  - imem_ack=0: remain in S_FETCH, any number of wait cycles.
  - imem_ack=1: instr<=imem_rdata; next state S_ISSUE.
  - Zero-wait ack (same cycle as first req) is legal.
- S_ISSUE:
  - imem_req=0, instr_valid=1, instr/opcode/pc stable.
  - stall=1: remain in S_ISSUE; nothing changes.
  - stall=0: instruction retires this cycle. Next PC, evaluated from jump/branch/zero sampled in this cycle, in priority order:
    - jump=1: pc<=jump_addr.
    - else branch=1 and zero=1: pc<=pc+1+branch_offset.
    - else: pc<=pc+1.
  - Next state S_FETCH.
- Throughput: with zero-wait memory and no stall, one instruction per 2 cycles (FETCH, ISSUE).
- Arithmetic: all PC sums truncated to PC_WIDTH (wrap). 16'hFFFF+1 -> 16'h0000. Negative offsets via two's complement.
- jump/branch/zero ignored outside S_ISSUE, and in S_ISSUE while stall=1.
- imem_ack ignored outside S_FETCH; a stray ack causes no state or data change.
- opcode is always instr[15:13]. When instr_valid=0 the datapath gates reg_write/mem_write. Stale opcode (3'b000 = add after reset) must not commit.
- Reset mid-operation:
  - Any outstanding fetch is abandoned; imem_req drops asynchronously.
  - A late ack after release lands in S_IDLE and is ignored.
  - Fetch restarts at RESET_PC.

Test Plan:
- Reset release, imem_ack tied 1, mem[0]=16'h0123, mem[1]=16'h2456 -> one S_IDLE cycle. Then instr=16'h0123, opcode=0, pc=0, instr_valid=1. Then pc=1, instr=16'h2456, opcode=1; valid every 2nd cycle.
- Ack delayed 3 cycles at pc=5 -> imem_req=1 with imem_addr=5 stable for 4 cycles; instr_valid rises the cycle after ack.
- stall=1 for 4 cycles in S_ISSUE at pc=7 -> instr/pc/instr_valid frozen. No imem_req. Next fetch at 8 after stall drops.
- Jump priority, pc=10: jump=1, branch=1, zero=1, jump_addr=16'h0040 -> next imem_addr=16'h0040.
- Branch, pc=16'h0020: branch=1, zero=1, offset=16'hFFFC -> next fetch 16'h001D. Same with zero=0 -> 16'h0021.
- pc=16'hFFFF, no branch -> next fetch 16'h0000. Reset asserted mid-S_FETCH with ack pending -> imem_req=0 immediately; restart at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Instruction-memory fetch bus: request/address out, data/acknowledge back.
// Combinational bundle with no latency; the acknowledge is the only backpressure.
// The address is held stable for as long as the request stays high.
interface instr_fetch_if #(
    parameter int PC_WIDTH = 16
) ();
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic [15:0]         imem_rdata;
    logic                imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch/issue sequencer: owns the PC, fetches over req/ack, issues one word at a time.
// Latency: one idle cycle after reset, then FETCH (1 + memory wait cycles) and ISSUE (>=1 cycle).
// Backpressure: imem_ack extends FETCH; stall holds ISSUE with instr/pc frozen.
module instr_fetch #(
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_if.master       imem,
    input  logic                stall,
    input  logic                jump,
    input  logic                branch,
    input  logic                zero,
    input  logic [PC_WIDTH-1:0] jump_addr,
    input  logic [PC_WIDTH-1:0] branch_offset,
    output logic [15:0]         instr,
    output logic [2:0]          opcode,
    output logic                instr_valid,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus1
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE
    } state_t;

    state_t              state, state_nxt;
    logic [PC_WIDTH-1:0] pc_q, pc_nxt;
    logic [15:0]         instr_q, instr_nxt;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] branch_target;

    // All PC arithmetic wraps at PC_WIDTH bits.
    assign pc_inc        = pc_q + PC_WIDTH'(1);
    assign branch_target = pc_inc + branch_offset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 16'h0000;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            instr_q <= instr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc_q;
        instr_nxt     = instr_q;
        imem.imem_req = 1'b0;
        instr_valid   = 1'b0;

        case (state)
            S_IDLE: begin
                state_nxt = S_FETCH;
            end

            S_FETCH: begin
                imem.imem_req = 1'b1;
                if (imem.imem_ack) begin
                    instr_nxt = imem.imem_rdata;
                    state_nxt = S_ISSUE;
                end
            end

            S_ISSUE: begin
                instr_valid = 1'b1;
                // Decoder results only matter on the cycle the instruction retires.
                if (!stall) begin
                    if (jump) begin
                        pc_nxt = jump_addr;
                    end else if (branch && zero) begin
                        pc_nxt = branch_target;
                    end else begin
                        pc_nxt = pc_inc;
                    end
                    state_nxt = S_FETCH;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // pc only moves on retire, so the address is stable for the whole request.
    assign imem.imem_addr = pc_q;
    assign instr          = instr_q;
    assign opcode         = instr_q[15:13];
    assign pc             = pc_q;
    assign pc_plus1       = pc_inc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: table of fetch/issue vectors, scoreboard of expected issued words,
// plus hand-written reset-release and reset-during-fetch sequences.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, jump, branch, zero;
    logic [15:0] jump_addr, branch_offset;
    logic [15:0] instr;
    logic [2:0]  opcode;
    logic        instr_valid;
    logic [15:0] pc, pc_plus1;

    always #5 clk = ~clk;

    instr_fetch_if #(.PC_WIDTH(16)) bus ();

    instr_fetch #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem          (bus.master),
        .stall         (stall),
        .jump          (jump),
        .branch        (branch),
        .zero          (zero),
        .jump_addr     (jump_addr),
        .branch_offset (branch_offset),
        .instr         (instr),
        .opcode        (opcode),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .pc_plus1      (pc_plus1)
    );

    // Memory model: acks after ack_wait cycles of request; force_ack injects stray acks with junk data.
    logic [15:0] mem [0:65535];
    int          ack_wait;
    logic        force_ack;
    int          wait_cnt;

    assign bus.imem_ack   = force_ack | (bus.imem_req & (wait_cnt >= ack_wait));
    assign bus.imem_rdata = force_ack ? 16'hDEAD : mem[bus.imem_addr];

    always @(posedge clk or posedge reset) begin
        if (reset)                               wait_cnt <= 0;
        else if (bus.imem_req && !bus.imem_ack)  wait_cnt <= wait_cnt + 1;
        else                                     wait_cnt <= 0;
    end

    typedef struct {
        logic [15:0] pc;
        logic [15:0] nxt;
        logic        jmp;
        logic        br;
        logic        z;
        logic [15:0] jaddr;
        logic [15:0] off;
        int          stall_n;
        int          ack_w;
    } vec_t;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] word;
    } sb_t;

    sb_t  sb[$];
    vec_t tbl[15];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from its fetch through retire; ends one cycle into the next fetch.
    task automatic run_entry(input vec_t r);
        int   req_cycles;
        bit   got;
        sb_t  e;
        logic [15:0] exp_p1;
        ack_wait   = r.ack_w;
        req_cycles = 0;
        got        = 0;
        sb.push_back('{pc: r.pc, word: mem[r.pc]});
        // Decoder inputs are garbage while fetching; they must be ignored.
        stall = 1'b0; jump = 1'b1; branch = 1'b1; zero = 1'b1;
        jump_addr = 16'hBEEF; branch_offset = 16'h0100;
        for (int k = 0; k < 20 && !got; k++) begin
            if (instr_valid) begin
                got = 1;
            end else begin
                if (bus.imem_req) begin
                    req_cycles++;
                    chk("fetch_addr", 32'(bus.imem_addr), 32'(r.pc));
                end
                step();
            end
        end
        if (!got || sb.size() == 0) begin
            chk("issue_timeout", 32'(got), 32'd1);
            return;
        end
        e = sb.pop_front();
        exp_p1 = r.pc + 16'h0001;
        chk("instr",      32'(instr),       32'(e.word));
        chk("opcode",     32'(opcode),      32'(e.word[15:13]));
        chk("issue_pc",   32'(pc),          32'(e.pc));
        chk("pc_plus1",   32'(pc_plus1),    32'(exp_p1));
        chk("req_cycles", 32'(req_cycles),  32'(r.ack_w + 1));
        chk("issue_req",  32'(bus.imem_req), 32'd0);
        // Stall with stray ack and a bogus jump: nothing may move.
        stall = 1'b1; force_ack = 1'b1; jump = 1'b1; jump_addr = 16'h1234;
        for (int s = 0; s < r.stall_n; s++) begin
            step();
            chk("stall_valid", 32'(instr_valid),  32'd1);
            chk("stall_instr", 32'(instr),        32'(e.word));
            chk("stall_pc",    32'(pc),           32'(e.pc));
            chk("stall_req",   32'(bus.imem_req), 32'd0);
        end
        stall = 1'b0; force_ack = 1'b0;
        jump = r.jmp; branch = r.br; zero = r.z;
        jump_addr = r.jaddr; branch_offset = r.off;
        step();
        chk("next_req",   32'(bus.imem_req),  32'd1);
        chk("next_addr",  32'(bus.imem_addr), 32'(r.nxt));
        chk("next_valid", 32'(instr_valid),   32'd0);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 16'(a * 40503 + 4951);
        mem[0] = 16'h0123;
        mem[1] = 16'h2456;

        //             pc        nxt       j     b     z     jaddr     off       stall ackw
        tbl[0]  = '{16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 0, 0};
        tbl[1]  = '{16'h0001, 16'h0005, 1'b1, 1'b0, 1'b0, 16'h0005, 16'h0000, 0, 0};
        tbl[2]  = '{16'h0005, 16'h0006, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 0, 3};
        tbl[3]  = '{16'h0006, 16'h0007, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 0, 0};
        tbl[4]  = '{16'h0007, 16'h0008, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4, 0};
        tbl[5]  = '{16'h0008, 16'h000A, 1'b1, 1'b0, 1'b0, 16'h000A, 16'h0000, 0, 0};
        tbl[6]  = '{16'h000A, 16'h0040, 1'b1, 1'b1, 1'b1, 16'h0040, 16'h0005, 0, 0};
        tbl[7]  = '{16'h0040, 16'h0020, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000, 0, 1};
        tbl[8]  = '{16'h0020, 16'h001D, 1'b0, 1'b1, 1'b1, 16'h0000, 16'hFFFC, 0, 0};
        tbl[9]  = '{16'h001D, 16'h0020, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000, 0, 0};
        tbl[10] = '{16'h0020, 16'h0021, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFFC, 0, 0};
        tbl[11] = '{16'h0021, 16'h0022, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0100, 0, 0};
        tbl[12] = '{16'h0022, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 0, 2};
        tbl[13] = '{16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 0, 1};
        tbl[14] = '{16'h0000, 16'h0008, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0007, 2, 0};

        reset = 1'b1; force_ack = 1'b1; ack_wait = 0;
        stall = 1'b0; jump = 1'b0; branch = 1'b0; zero = 1'b0;
        jump_addr = 16'h0000; branch_offset = 16'h0000;
        step();
        step();
        chk("rst_req",    32'(bus.imem_req),  32'd0);
        chk("rst_valid",  32'(instr_valid),   32'd0);
        chk("rst_addr",   32'(bus.imem_addr), 32'h0000);
        chk("rst_pc",     32'(pc),            32'h0000);
        chk("rst_instr",  32'(instr),         32'h0000);
        chk("rst_opcode", 32'(opcode),        32'd0);

        // Exactly one idle cycle after release; a stray ack there is ignored.
        reset = 1'b0;
        #1;
        chk("idle_req",   32'(bus.imem_req), 32'd0);
        chk("idle_valid", 32'(instr_valid),  32'd0);
        step();
        chk("first_fetch_req", 32'(bus.imem_req), 32'd1);
        force_ack = 1'b0;

        for (int i = 0; i < 15; i++) run_entry(tbl[i]);

        // Reset while a fetch is waiting on its ack.
        ack_wait = 1000;
        step();
        chk("pend_req",  32'(bus.imem_req),  32'd1);
        chk("pend_addr", 32'(bus.imem_addr), 32'h0008);
        #2;
        reset = 1'b1;
        #1;
        chk("async_req_drop", 32'(bus.imem_req),  32'd0);
        chk("async_addr",     32'(bus.imem_addr), 32'h0000);
        chk("async_valid",    32'(instr_valid),   32'd0);
        force_ack = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("late_ack_req",   32'(bus.imem_req), 32'd0);
        chk("late_ack_valid", 32'(instr_valid),  32'd0);
        chk("late_ack_instr", 32'(instr),        32'h0000);
        step();
        force_ack = 1'b0;
        run_entry('{16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 0, 0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck, expected completion");
        $fatal(1, "timeout");
    end

endmodule
